reg_cc_ben: RTL and testbench

REG_CC_BEN -- requirements
Module: reg_cc_ben

---
 rtl/reg_cc_ben.sv | 99 +++++++++
 tb/tb_reg_cc_ben.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_cc_ben.sv
// Eight-entry register file with NZP condition codes and a registered branch-enable flag.
// Reads are combinational; writes, NZP and BEN update on the rising clock edge.
module reg_cc_ben #(
  parameter int unsigned WIDTH  = 16,
  parameter logic [2:0]  CC_RST = 3'b010
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [15:0]      IR,
  input  logic             LD_REG,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic [1:0]       DRMUX,
  input  logic [1:0]       SR1MUX,
  input  logic [2:0]       dbg_sel,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  output logic [WIDTH-1:0] dbg_data,
  output logic             N,
  output logic             Z,
  output logic             P,
  output logic             branch_enable
);

  logic [WIDTH-1:0] r_regs [8];
  logic [2:0]       r_nzp;
  logic             r_ben;

  logic [2:0]       w_dr;
  logic [2:0]       w_sr1;
  logic [2:0]       w_sr2;
  logic [2:0]       w_nzp_next;
  logic             w_ben_next;
  logic             w_unused_ir;

  assign w_unused_ir = ^{IR[15:12], IR[5:3]};

  always_comb begin
    w_dr = IR[11:9];
    unique case (DRMUX)
      2'b01:   w_dr = 3'b111;
      2'b10:   w_dr = 3'b110;
      default: w_dr = IR[11:9];
    endcase
  end

  always_comb begin
    w_sr1 = IR[11:9];
    unique case (SR1MUX)
      2'b00:   w_sr1 = IR[11:9];
      2'b10:   w_sr1 = 3'b110;
      default: w_sr1 = IR[8:6];
    endcase
  end

  assign w_sr2 = IR[2:0];

  always_comb begin
    w_nzp_next = 3'b001;
    if (bus_in[WIDTH-1])
      w_nzp_next = 3'b100;
    else if (bus_in == '0)
      w_nzp_next = 3'b010;
  end

  // BEN samples the NZP held before this edge, even when LD_CC loads it in the same cycle.
  assign w_ben_next = (IR[11] & r_nzp[2]) | (IR[10] & r_nzp[1]) | (IR[9] & r_nzp[0]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 8; i++)
        r_regs[i] <= '0;
    end else if (LD_REG) begin
      r_regs[w_dr] <= bus_in;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_nzp <= CC_RST;
      r_ben <= 1'b0;
    end else begin
      if (LD_CC)
        r_nzp <= w_nzp_next;
      if (LD_BEN)
        r_ben <= w_ben_next;
    end
  end

  assign SR1_OUT       = r_regs[w_sr1];
  assign SR2_OUT       = r_regs[w_sr2];
  assign dbg_data      = r_regs[dbg_sel];
  assign N             = r_nzp[2];
  assign Z             = r_nzp[1];
  assign P             = r_nzp[0];
  assign branch_enable = r_ben;

endmodule

// File: tb/tb_reg_cc_ben.sv
// Self-checking bench for reg_cc_ben: directed scenarios plus randomized traffic
// compared against a behavioural register-file / condition-code model.
`timescale 1ns/1ps
module tb_reg_cc_ben;

  logic        Clk;
  logic        Reset;
  logic [15:0] bus_in;
  logic [15:0] IR;
  logic        LD_REG, LD_CC, LD_BEN;
  logic [1:0]  DRMUX, SR1MUX;
  logic [2:0]  dbg_sel;
  logic [15:0] SR1_OUT, SR2_OUT, dbg_data;
  logic        N, Z, P, branch_enable;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [8];
  bit          m_n, m_z, m_p, m_ben;

  reg_cc_ben #(.WIDTH(16), .CC_RST(3'b010)) dut (
    .Clk(Clk), .Reset(Reset), .bus_in(bus_in), .IR(IR),
    .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .dbg_sel(dbg_sel),
    .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .dbg_data(dbg_data),
    .N(N), .Z(Z), .P(P), .branch_enable(branch_enable)
  );

  initial Clk = 1'b0;
  always #20 Clk = ~Clk;

  function automatic int dest_of(input logic [1:0] sel, input logic [15:0] ir);
    if (sel == 2'd1) return 7;
    if (sel == 2'd2) return 6;
    return int'(ir[11:9]);
  endfunction

  function automatic int src1_of(input logic [1:0] sel, input logic [15:0] ir);
    if (sel == 2'd0) return int'(ir[11:9]);
    if (sel == 2'd2) return 6;
    return int'(ir[8:6]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_n = 0; m_z = 1; m_p = 0; m_ben = 0;
  endtask

  // Applies the architectural effect of one rising edge with the current inputs.
  task automatic model_edge();
    bit b;
    if (Reset) begin
      model_reset();
      return;
    end
    b = (IR[11] && m_n) || (IR[10] && m_z) || (IR[9] && m_p);
    if (LD_REG) m_regs[dest_of(DRMUX, IR)] = bus_in;
    if (LD_CC) begin
      m_n = (bus_in >= 16'h8000);
      m_z = (bus_in == 16'h0000);
      m_p = !m_n && !m_z;
    end
    if (LD_BEN) m_ben = b;
  endtask

  task automatic idle();
    LD_REG = 0; LD_CC = 0; LD_BEN = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    Reset = 1; idle(); bus_in = 16'hFFFF; IR = 16'h0000;
    DRMUX = 0; SR1MUX = 0; dbg_sel = 0;
    #3;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i); #1; checks++;
      if (dbg_data !== 16'h0000) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected 0000", i, dbg_data);
      end
    end
    checks++;
    if ({N, Z, P} !== 3'b010) begin
      errors++; $display("FAIL reset_nzp: got %b expected 010", {N, Z, P});
    end
    checks++;
    if (branch_enable !== 1'b0) begin
      errors++; $display("FAIL reset_ben: got %b expected 0", branch_enable);
    end
    @(negedge Clk); Reset = 0;
  endtask

  task automatic test_write_cc();
    @(negedge Clk);
    IR = 16'h1A40; DRMUX = 2'b00; SR1MUX = 2'b00; bus_in = 16'h8001;
    LD_REG = 1; LD_CC = 1; LD_BEN = 0; dbg_sel = 3'd5;
    #1; checks++;
    if (SR1_OUT !== 16'h0000) begin
      errors++; $display("FAIL no_bypass_pre: got %h expected 0000", SR1_OUT);
    end
    tick();
    checks++;
    if (dbg_data !== 16'h8001) begin
      errors++; $display("FAIL write_r5: got %h expected 8001", dbg_data);
    end
    checks++;
    if (SR1_OUT !== 16'h8001) begin
      errors++; $display("FAIL no_bypass_post: got %h expected 8001", SR1_OUT);
    end
    checks++;
    if ({N, Z, P} !== 3'b100) begin
      errors++; $display("FAIL cc_negative: got %b expected 100", {N, Z, P});
    end
  endtask

  task automatic test_write_r7();
    @(negedge Clk);
    idle(); DRMUX = 2'b01; bus_in = 16'h3000; LD_REG = 1;
    tick();
    @(negedge Clk); idle();
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i); #1; checks++;
      if (dbg_data !== m_regs[i]) begin
        errors++; $display("FAIL r7_write_reg%0d: got %h expected %h", i, dbg_data, m_regs[i]);
      end
    end
    dbg_sel = 3'd7; #1; checks++;
    if (dbg_data !== 16'h3000) begin
      errors++; $display("FAIL r7_value: got %h expected 3000", dbg_data);
    end
  endtask

  task automatic test_ben();
    @(negedge Clk);
    idle(); IR = 16'h0800; LD_BEN = 1;
    tick(); checks++;
    if (branch_enable !== 1'b1) begin
      errors++; $display("FAIL ben_brn: got %b expected 1", branch_enable);
    end
    @(negedge Clk); IR = 16'h0600;
    tick(); checks++;
    if (branch_enable !== 1'b0) begin
      errors++; $display("FAIL ben_brzp: got %b expected 0", branch_enable);
    end
    @(negedge Clk); idle(); IR = 16'h0E00;
    tick(); checks++;
    if (branch_enable !== 1'b0) begin
      errors++; $display("FAIL ben_hold: got %b expected 0", branch_enable);
    end
  endtask

  task automatic test_cc_ben_same_cycle();
    @(negedge Clk);
    idle(); bus_in = 16'h0000; LD_CC = 1;
    tick(); checks++;
    if ({N, Z, P} !== 3'b010) begin
      errors++; $display("FAIL cc_zero: got %b expected 010", {N, Z, P});
    end
    @(negedge Clk);
    bus_in = 16'h0005; IR = 16'h0400; LD_CC = 1; LD_BEN = 1;
    tick(); checks++;
    if (branch_enable !== 1'b1) begin
      errors++; $display("FAIL ben_old_z: got %b expected 1", branch_enable);
    end
    checks++;
    if ({N, Z, P} !== 3'b001) begin
      errors++; $display("FAIL cc_positive: got %b expected 001", {N, Z, P});
    end
  endtask

  task automatic test_async_reset();
    @(negedge Clk);
    idle(); IR = 16'h0600; DRMUX = 2'b00; bus_in = 16'hBEEF;
    LD_REG = 1; LD_BEN = 1; dbg_sel = 3'd3;
    tick(); checks++;
    if (dbg_data !== 16'hBEEF || branch_enable !== 1'b1) begin
      errors++; $display("FAIL pre_reset_state: got %h/%b expected BEEF/1", dbg_data, branch_enable);
    end
    #4; Reset = 1; #1;
    model_reset();
    checks++;
    if (dbg_data !== 16'h0000) begin
      errors++; $display("FAIL async_reset_r3: got %h expected 0000", dbg_data);
    end
    checks++;
    if (branch_enable !== 1'b0 || {N, Z, P} !== 3'b010) begin
      errors++; $display("FAIL async_reset_cc: got %b/%b expected 0/010", branch_enable, {N, Z, P});
    end
    // Loads stay active across an edge while Reset is held.
    LD_CC = 1; bus_in = 16'hBEEF;
    tick(); checks++;
    if (dbg_data !== 16'h0000 || {N, Z, P} !== 3'b010 || branch_enable !== 1'b0) begin
      errors++; $display("FAIL reset_wins: got %h/%b/%b expected 0000/010/0", dbg_data, {N, Z, P}, branch_enable);
    end
    @(negedge Clk); Reset = 0; idle();
    bus_in = 16'h1234; LD_REG = 1; LD_CC = 1;
    tick(); checks++;
    if (dbg_data !== 16'h1234 || {N, Z, P} !== 3'b001) begin
      errors++; $display("FAIL first_edge_after_reset: got %h/%b expected 1234/001", dbg_data, {N, Z, P});
    end
  endtask

  task automatic test_random();
    bit do_rst;
    for (int it = 0; it < 400; it++) begin
      @(negedge Clk);
      Reset = 0;
      IR = 16'($urandom); DRMUX = 2'($urandom); SR1MUX = 2'($urandom);
      dbg_sel = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       bus_in = 16'h0000;
        1:       bus_in = 16'h8000 | 16'($urandom);
        default: bus_in = 16'($urandom);
      endcase
      LD_REG = 1'($urandom); LD_CC = 1'($urandom); LD_BEN = 1'($urandom);
      do_rst = ($urandom_range(0, 39) == 0);
      #1; checks++;
      if (SR1_OUT !== m_regs[src1_of(SR1MUX, IR)] || SR2_OUT !== m_regs[IR[2:0]]
          || dbg_data !== m_regs[dbg_sel]) begin
        errors++;
        $display("FAIL rand_read it=%0d: got %h/%h/%h expected %h/%h/%h", it, SR1_OUT, SR2_OUT,
                 dbg_data, m_regs[src1_of(SR1MUX, IR)], m_regs[IR[2:0]], m_regs[dbg_sel]);
      end
      if (do_rst) begin
        #2; Reset = 1;
      end
      tick(); checks++;
      if ({N, Z, P} !== {m_n, m_z, m_p} || branch_enable !== m_ben) begin
        errors++;
        $display("FAIL rand_cc it=%0d: got %b/%b expected %b/%b", it, {N, Z, P}, branch_enable,
                 {m_n, m_z, m_p}, m_ben);
      end
      if (it % 25 == 0) begin
        for (int i = 0; i < 8; i++) begin
          dbg_sel = 3'(i); #1; checks++;
          if (dbg_data !== m_regs[i]) begin
            errors++; $display("FAIL rand_sweep it=%0d reg%0d: got %h expected %h", it, i, dbg_data, m_regs[i]);
          end
        end
      end
    end
    @(negedge Clk); Reset = 0; idle();
  endtask

  initial begin
    test_reset();
    test_write_cc();
    test_write_r7();
    test_ben();
    test_cc_ben_same_cycle();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
